// File: rtl/matcher_pkg.sv
// -----------------------------------------------------------------------------
// matcher_pkg
//   Shared definitions for the vocabulary matcher: FSM state encoding, the NUL
//   character value and the match-mode encodings.
//   No ports (package).
// -----------------------------------------------------------------------------
package matcher_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CMP,
      SKIP_RD,
      SKIP_CMP,
      DONE
   } state_t;

   localparam int   NUL          = 0;
   localparam logic MATCH_EXACT  = 1'b0;
   localparam logic MATCH_PREFIX = 1'b1;

endpackage

// File: rtl/match_word_buf.sv
// -----------------------------------------------------------------------------
// match_word_buf
//   Holds the query word for the duration of a scan and serves its characters
//   one at a time.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     i_load      : latch i_word (and its length) this cycle
//     i_word      : query, character 0 in the LSBs
//     i_index     : character index to read from the latched word
//     o_in_len    : length of i_word as presented now (before latching)
//     o_len       : length of the latched word
//     o_char      : latched character at i_index, 0 when i_index >= o_len
// -----------------------------------------------------------------------------
module match_word_buf
   import matcher_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int MAX_WORD_LEN = 16,
   parameter int LEN_W        = $clog2(MAX_WORD_LEN + 1)
)(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               i_load,
   input  logic [MAX_WORD_LEN*DATA_WIDTH-1:0] i_word,
   input  logic [LEN_W-1:0]                   i_index,
   output logic [LEN_W-1:0]                   o_in_len,
   output logic [LEN_W-1:0]                   o_len,
   output logic [DATA_WIDTH-1:0]              o_char
);

   logic [DATA_WIDTH-1:0]   w_in_chars [MAX_WORD_LEN];
   logic [MAX_WORD_LEN-1:0] w_in_nul;
   logic [LEN_W-1:0]        w_in_len;
   logic [DATA_WIDTH-1:0]   r_chars [MAX_WORD_LEN];
   logic [LEN_W-1:0]        r_len;

   genvar gi;
   generate
      for (gi = 0; gi < MAX_WORD_LEN; gi++) begin : g_unpack
         assign w_in_chars[gi] = i_word[gi*DATA_WIDTH +: DATA_WIDTH];
         assign w_in_nul[gi]   = (w_in_chars[gi] == DATA_WIDTH'(NUL));
      end
   endgenerate

   // Priority encoder: lowest-index NUL wins; no NUL means full length.
   always_comb begin
      w_in_len = LEN_W'(MAX_WORD_LEN);
      for (int k = MAX_WORD_LEN - 1; k >= 0; k--) begin
         if (w_in_nul[k]) begin
            w_in_len = LEN_W'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len <= '0;
         for (int k = 0; k < MAX_WORD_LEN; k++) begin
            r_chars[k] <= '0;
         end
      end else if (i_load) begin
         r_len <= w_in_len;
         for (int k = 0; k < MAX_WORD_LEN; k++) begin
            r_chars[k] <= w_in_chars[k];
         end
      end
   end

   // Characters past the first NUL may be garbage, so they are masked to 0.
   always_comb begin
      o_char = '0;
      for (int k = 0; k < MAX_WORD_LEN; k++) begin
         if ((i_index == LEN_W'(k)) && (LEN_W'(k) < r_len)) begin
            o_char = r_chars[k];
         end
      end
   end

   assign o_in_len = w_in_len;
   assign o_len    = r_len;

endmodule

// File: rtl/vocab_matcher.sv
// -----------------------------------------------------------------------------
// vocab_matcher
//   Scans a window of a NUL-terminated vocabulary memory for a query word and
//   reports the token index / start address of the first matching entry.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     start                 : start request (sampled only in IDLE)
//     mode                  : 0 exact, 1 prefix (query is prefix of entry)
//     start_addr, end_addr  : inclusive scan window
//     word                  : query, character 0 in LSBs
//     vocab_rd_en/addr      : read port to the synchronous vocab SRAM
//     vocab_rdata           : read data, valid the cycle after vocab_rd_en
//     busy, done            : scan in progress / one-cycle completion pulse
//     found, token_id,
//     match_addr, overflow  : results, held until the next start
// -----------------------------------------------------------------------------
module vocab_matcher
   import matcher_pkg::*;
#(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 8,
   parameter int MAX_WORD_LEN = 16,
   parameter int TOKEN_WIDTH  = 8
)(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic                               mode,
   input  logic [ADDR_WIDTH-1:0]              start_addr,
   input  logic [ADDR_WIDTH-1:0]              end_addr,
   input  logic [MAX_WORD_LEN*DATA_WIDTH-1:0] word,
   output logic                               vocab_rd_en,
   output logic [ADDR_WIDTH-1:0]              vocab_addr,
   input  logic [DATA_WIDTH-1:0]              vocab_rdata,
   output logic                               busy,
   output logic                               done,
   output logic                               found,
   output logic [TOKEN_WIDTH-1:0]             token_id,
   output logic [ADDR_WIDTH-1:0]              match_addr,
   output logic                               overflow
);

   localparam int IDX_W = $clog2(MAX_WORD_LEN + 1);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [ADDR_WIDTH-1:0]  r_end_addr;
   logic [ADDR_WIDTH-1:0]  r_entry;
   logic [IDX_W-1:0]       r_idx;
   logic [TOKEN_WIDTH-1:0] r_tok;
   logic                   r_mode;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_found;
   logic [TOKEN_WIDTH-1:0] r_token_id;
   logic [ADDR_WIDTH-1:0]  r_match_addr;
   logic                   r_overflow;

   logic [IDX_W-1:0]      w_len;
   logic [IDX_W-1:0]      w_in_len;
   logic [DATA_WIDTH-1:0] w_char;
   logic                  w_b_nul;
   logic                  w_b_eq;
   logic                  w_accept;
   logic                  w_hit;
   logic                  w_ovf;
   logic                  w_addr_inc;
   logic                  w_idx_inc;
   logic                  w_new_entry;
   logic                  w_rd_en;

   match_word_buf #(
      .DATA_WIDTH   (DATA_WIDTH),
      .MAX_WORD_LEN (MAX_WORD_LEN),
      .LEN_W        (IDX_W)
   ) u_word_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_accept),
      .i_word   (word),
      .i_index  (r_idx),
      .o_in_len (w_in_len),
      .o_len    (w_len),
      .o_char   (w_char)
   );

   assign w_b_nul = (vocab_rdata == DATA_WIDTH'(NUL));
   assign w_b_eq  = (vocab_rdata == w_char);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state plus one-hot-ish action strobes consumed by the datapath.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_hit        = 1'b0;
      w_ovf        = 1'b0;
      w_addr_inc   = 1'b0;
      w_idx_inc    = 1'b0;
      w_new_entry  = 1'b0;
      w_rd_en      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = (w_in_len == '0) ? DONE : RD;
            end
         end
         RD: begin
            w_rd_en      = 1'b1;
            w_state_next = CMP;
         end
         CMP: begin
            if (w_b_nul && (r_idx == '0)) begin
               // Empty entry marks the end of the vocabulary.
               w_state_next = DONE;
            end else if ((w_b_eq && w_b_nul) ||
                         ((r_mode == MATCH_PREFIX) && (r_idx == w_len) && !w_b_nul)) begin
               w_hit        = 1'b1;
               w_state_next = DONE;
            end else if (r_addr == r_end_addr) begin
               w_ovf        = 1'b1;
               w_state_next = DONE;
            end else if (w_b_eq) begin
               w_idx_inc    = 1'b1;
               w_addr_inc   = 1'b1;
               w_state_next = RD;
            end else if (w_b_nul) begin
               // Entry ended before the query did: move to the next entry.
               w_new_entry  = 1'b1;
               w_addr_inc   = 1'b1;
               w_state_next = RD;
            end else begin
               w_addr_inc   = 1'b1;
               w_state_next = SKIP_RD;
            end
         end
         SKIP_RD: begin
            w_rd_en      = 1'b1;
            w_state_next = SKIP_CMP;
         end
         SKIP_CMP: begin
            if (r_addr == r_end_addr) begin
               w_ovf        = 1'b1;
               w_state_next = DONE;
            end else if (w_b_nul) begin
               w_new_entry  = 1'b1;
               w_addr_inc   = 1'b1;
               w_state_next = RD;
            end else begin
               w_addr_inc   = 1'b1;
               w_state_next = SKIP_RD;
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr       <= '0;
         r_end_addr   <= '0;
         r_entry      <= '0;
         r_idx        <= '0;
         r_tok        <= '0;
         r_mode       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_found      <= 1'b0;
         r_token_id   <= '0;
         r_match_addr <= '0;
         r_overflow   <= 1'b0;
      end else begin
         // done follows the DONE state by one cycle, which is also when busy drops.
         r_done <= (r_state == DONE);
         if (r_state == DONE) begin
            r_busy <= 1'b0;
         end
         if (w_accept) begin
            r_mode     <= mode;
            r_end_addr <= end_addr;
            r_addr     <= start_addr;
            r_entry    <= start_addr;
            r_idx      <= '0;
            r_tok      <= '0;
            r_found    <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
         end
         if (w_hit) begin
            r_found      <= 1'b1;
            r_token_id   <= r_tok;
            r_match_addr <= r_entry;
         end
         if (w_ovf) begin
            r_overflow <= 1'b1;
         end
         if (w_addr_inc) begin
            r_addr <= r_addr + 1'b1;
         end
         if (w_idx_inc) begin
            r_idx <= r_idx + 1'b1;
         end
         if (w_new_entry) begin
            r_idx   <= '0;
            r_tok   <= r_tok + 1'b1;
            r_entry <= r_addr + 1'b1;
         end
      end
   end

   assign vocab_rd_en = w_rd_en;
   assign vocab_addr  = w_rd_en ? r_addr : '0;
   assign busy        = r_busy;
   assign done        = r_done;
   assign found       = r_found;
   assign token_id    = r_token_id;
   assign match_addr  = r_match_addr;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_vocab_matcher.sv
// -----------------------------------------------------------------------------
// tb_vocab_matcher
//   Directed and randomized bench for vocab_matcher with a behavioural SRAM and
//   an entry-level reference model.
// -----------------------------------------------------------------------------
module tb_vocab_matcher;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         mode = 1'b0;
   logic [7:0]   start_addr = 8'd0;
   logic [7:0]   end_addr = 8'd0;
   logic [127:0] word = '0;
   logic         vocab_rd_en;
   logic [7:0]   vocab_addr;
   logic [7:0]   vocab_rdata;
   logic         busy;
   logic         done;
   logic         found;
   logic [7:0]   token_id;
   logic [7:0]   match_addr;
   logic         overflow;

   logic [7:0]   mem [256];
   logic [7:0]   q [16];
   int           starts [$];
   int           n_checks = 0;
   int           n_fail = 0;

   vocab_matcher dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .mode        (mode),
      .start_addr  (start_addr),
      .end_addr    (end_addr),
      .word        (word),
      .vocab_rd_en (vocab_rd_en),
      .vocab_addr  (vocab_addr),
      .vocab_rdata (vocab_rdata),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .token_id    (token_id),
      .match_addr  (match_addr),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Synchronous SRAM, one cycle read latency.
   always @(posedge clk) begin
      if (vocab_rd_en) begin
         vocab_rdata <= mem[vocab_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill_mem(input logic [7:0] v);
      for (int k = 0; k < 256; k++) mem[k] = v;
   endtask

   // '.' in the string stands for NUL.
   task automatic load_vocab(input string s, input int base);
      for (int k = 0; k < s.len(); k++) mem[base + k] = (s[k] == 8'h2E) ? 8'h00 : s[k];
   endtask

   task automatic set_word(input string s);
      word = '0;
      for (int k = 0; k < s.len(); k++) word[k*8 +: 8] = s[k];
   endtask

   // Reference: walk whole entries. An entry hits when its decision character
   // (query length past the entry start) lies inside the window; a missed entry
   // whose terminator is not strictly before end_addr ends the scan as overflow.
   function automatic void model(input bit m, input int sa, input int ea, input int qlen,
                                 output bit f, output int tok, output int maddr, output bit ovf);
      int pos;
      int t;
      bit ok;
      f = 0; tok = 0; maddr = 0; ovf = 0;
      if (qlen == 0) return;
      pos = sa;
      while (1) begin
         if (mem[pos] == 8'h00) return;
         if (pos + qlen <= ea) begin
            ok = 1;
            for (int k = 0; k < qlen; k++) if (mem[pos + k] != q[k]) ok = 0;
            if (!m && mem[pos + qlen] != 8'h00) ok = 0;
            if (ok) begin
               f = 1;
               maddr = pos;
               return;
            end
         end
         t = pos;
         while (t <= ea && mem[t] != 8'h00) t++;
         if (t >= ea) begin
            ovf = 1;
            return;
         end
         pos = t + 1;
         tok = (tok + 1) % 256;
      end
   endfunction

   task automatic run(input string tag, input bit m, input int sa, input int ea, input int poke_at,
                      output int last_rd, output int max_rd);
      int cycles;
      bit got_done;
      @(negedge clk);
      mode = m; start_addr = 8'(sa); end_addr = 8'(ea); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cycles = 1; last_rd = -1; max_rd = -1; got_done = 0;
      while (cycles < 3000) begin
         start = (cycles == poke_at);
         if (start) begin
            mode = ~m; start_addr = 8'd8; end_addr = 8'd2;
         end
         if (vocab_rd_en) begin
            last_rd = int'(vocab_addr);
            if (int'(vocab_addr) > max_rd) max_rd = int'(vocab_addr);
         end
         if (done) begin
            got_done = 1;
            break;
         end
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, 32'(got_done), 1);
      chk({tag, "_busy_at_done"}, 32'(busy), 0);
   endtask

   task automatic check_res(input string tag, input bit ef, input int etok, input int ema, input bit eovf);
      chk({tag, "_found"}, 32'(found), 32'(ef));
      chk({tag, "_overflow"}, 32'(overflow), 32'(eovf));
      if (ef) begin
         chk({tag, "_token_id"}, 32'(token_id), 32'(etok));
         chk({tag, "_match_addr"}, 32'(match_addr), 32'(ema));
      end
      @(negedge clk);
      chk({tag, "_done_pulse_width"}, 32'(done), 0);
      $display("txn %s: found=%0d token_id=%0d match_addr=%0d overflow=%0d (exp %0d/%0d/%0d/%0d)",
               tag, found, token_id, match_addr, overflow, ef, etok, ema, eovf);
   endtask

   task automatic gen_vocab();
      int p;
      int l;
      p = 0;
      starts.delete();
      while (p < 256) begin
         if ($urandom_range(0, 15) == 0) begin
            mem[p] = 8'h00;
            p++;
         end else begin
            starts.push_back(p);
            l = int'($urandom_range(1, 5));
            for (int k = 0; k < l && p < 256; k++) begin
               mem[p] = 8'h41 + 8'($urandom_range(0, 2));
               p++;
            end
            if (p < 256) begin
               mem[p] = 8'h00;
               p++;
            end
         end
      end
   endtask

   initial begin
      int lr, mr;
      int e, l, sel, qn, sa, ea, qlen, etok, ema;
      bit ef, eovf;

      // Reset state.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_outputs", {27'd0, busy, done, found, overflow, vocab_rd_en}, 0);
      chk("reset_token_id", 32'(token_id), 0);
      chk("reset_match_addr", 32'(match_addr), 0);

      // Directed cases.
      fill_mem(8'h51);
      load_vocab("CAT.DOG..", 0);
      set_word("DOG");
      run("dog_exact", 0, 0, 15, -1, lr, mr);
      check_res("dog_exact", 1, 1, 4, 0);
      set_word("DO");
      run("do_exact", 0, 0, 15, -1, lr, mr);
      check_res("do_exact", 0, 0, 0, 0);
      run("do_prefix", 1, 0, 15, -1, lr, mr);
      check_res("do_prefix", 1, 1, 4, 0);

      fill_mem(8'h51);
      load_vocab("CATS.CAT..", 0);
      set_word("CAT");
      run("cats_cat", 0, 0, 15, -1, lr, mr);
      check_res("cats_cat", 1, 1, 5, 0);

      fill_mem(8'h51);
      load_vocab("AB.CDEFGHIJ", 0);
      set_word("ZZ");
      run("window_ovf", 0, 0, 5, -1, lr, mr);
      chk("window_ovf_last_rd", 32'(lr), 5);
      chk("window_ovf_max_rd", 32'(mr), 5);
      check_res("window_ovf", 0, 0, 0, 1);

      // Start while busy must not disturb the running scan.
      fill_mem(8'h51);
      load_vocab("CAT.DOG..", 0);
      set_word("DOG");
      run("busy_poke", 0, 0, 15, 3, lr, mr);
      check_res("busy_poke", 1, 1, 4, 0);

      // Empty word: done two cycles after start, found cleared.
      word = '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("empty_busy", 32'(busy), 1);
      chk("empty_done_early", 32'(done), 0);
      @(negedge clk);
      chk("empty_done", 32'(done), 1);
      chk("empty_found", 32'(found), 0);
      @(negedge clk);
      chk("empty_done_after", 32'(done), 0);

      // Reset mid-scan clears everything at once.
      set_word("DOG");
      run("pre_reset", 0, 0, 15, -1, lr, mr);
      check_res("pre_reset", 1, 1, 4, 0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_flags", {27'd0, busy, done, found, overflow, vocab_rd_en}, 0);
      chk("midreset_token_id", 32'(token_id), 0);
      chk("midreset_match_addr", 32'(match_addr), 0);
      chk("midreset_vocab_addr", 32'(vocab_addr), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back identical runs.
      set_word("CAT");
      run("b2b_1", 0, 0, 15, -1, lr, mr);
      check_res("b2b_1", 1, 0, 0, 0);
      run("b2b_2", 0, 0, 15, -1, lr, mr);
      check_res("b2b_2", 1, 0, 0, 0);

      // Randomized scans against the entry-level model.
      for (int n = 0; n < 48; n++) begin
         if (n % 8 == 0) gen_vocab();
         for (int k = 0; k < 16; k++) q[k] = 8'h00;
         e = starts[$urandom_range(0, starts.size() - 1)];
         l = 0;
         while (l < 16 && e + l < 256 && mem[e + l] != 8'h00) begin
            q[l] = mem[e + l];
            l++;
         end
         sel = int'($urandom_range(0, 9));
         if (sel == 4 || sel == 5) begin
            qn = int'($urandom_range(1, l));
            for (int k = qn; k < 16; k++) q[k] = 8'h00;
         end else if (sel == 6 || sel == 7) begin
            for (int k = 0; k < 16; k++) q[k] = 8'h00;
            qn = int'($urandom_range(1, 4));
            for (int k = 0; k < qn; k++) q[k] = 8'h41 + 8'($urandom_range(0, 2));
         end else if (sel == 8) begin
            if (l < 16) q[l] = 8'h41;
         end else if (sel == 9) begin
            for (int k = 0; k < 16; k++) q[k] = 8'h00;
         end
         if ($urandom_range(0, 3) != 0) sa = starts[$urandom_range(0, starts.size() - 1)];
         else sa = int'($urandom_range(0, 250));
         ea = int'($urandom_range(sa, 255));
         qlen = 16;
         for (int k = 15; k >= 0; k--) if (q[k] == 8'h00) qlen = k;
         word = '0;
         for (int k = 0; k < 16; k++) word[k*8 +: 8] = q[k];
         model(bit'(n % 2), sa, ea, qlen, ef, etok, ema, eovf);
         run($sformatf("rnd%0d", n), bit'(n % 2), sa, ea, -1, lr, mr);
         chk($sformatf("rnd%0d_rd_window", n), 32'((mr > ea) || (mr >= 0 && mr < sa)), 0);
         check_res($sformatf("rnd%0d", n), ef, etok, ema, eovf);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
